// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexed scan controller for a multi-digit
// common-anode 7-segment display sharing one BCD-to-segment decoder.
//
// A scan frame walks digit 0 .. NUM_DIGITS-1. Each digit gets a BLANK slot
// of BLANK_CYCLES (all anodes off, decoder input pre-settled to the coming
// digit) followed by a SHOW slot of REFRESH_DIV cycles (that digit's anode
// on). New display words are staged and promoted to the shadow register
// only at a frame boundary, so a frame never mixes old and new digits.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (idx>0) are driven as 4'hF (blank)
//   undefined -> every digit drives its stored value, zeros included
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         scan enable; 0 = dark, scan parked at digit 0
//   load       one-cycle strobe to capture digits_in
//   digits_in  packed BCD, digit 0 (rightmost) in [3:0]
//   bcd_out    decoder BCD input; 4'hF renders blank
//   an_n       active-low anode enables, at most one low
//   frame_done one-cycle pulse after the last digit's SHOW slot
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  // Every digit slot opens with BLANK unless the blank slot is configured away.
  localparam state_t SLOT_FIRST = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  state_t                  r_state, w_state;
  logic [IW-1:0]           r_idx, w_idx;
  logic [CW-1:0]           r_cnt, w_cnt;
  logic [4*NUM_DIGITS-1:0] r_shadow, w_shadow;
  logic [4*NUM_DIGITS-1:0] r_staging, w_staging;
  logic                    r_pending, w_pending;
  logic                    w_fd, w_frame_end;
  logic [NUM_DIGITS-1:0]   r_an, w_an;
  logic [3:0]              r_bcd, w_bcd;
  logic                    r_fd;
  logic [3:0]              w_dig [NUM_DIGITS];

  assign an_n       = r_an;
  assign bcd_out    = r_bcd;
  assign frame_done = r_fd;

  // Next-state: slot sequencing plus shadow/staging bookkeeping.
  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_cnt       = r_cnt;
    w_shadow    = r_shadow;
    w_staging   = r_staging;
    w_pending   = r_pending;
    w_fd        = 1'b0;
    w_frame_end = (r_state == SHOW) && (r_idx == LAST_IDX) && (r_cnt == SHOW_LAST);

    if (!en) begin
      // Going dark is a frame boundary too: flush any staged word now.
      w_state   = IDLE;
      w_idx     = '0;
      w_cnt     = '0;
      w_pending = 1'b0;
      if (load)           w_shadow = digits_in;
      else if (r_pending) w_shadow = r_staging;
    end else begin
      case (r_state)
        IDLE: begin
          w_state = SLOT_FIRST;
          w_idx   = '0;
          w_cnt   = '0;
          if (load) w_shadow = digits_in;
        end
        BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state = SHOW;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_state = SLOT_FIRST;
            w_cnt   = '0;
            if (r_idx == LAST_IDX) begin
              w_idx = '0;
              w_fd  = 1'b1;
            end else begin
              w_idx = r_idx + 1'b1;
            end
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        default: w_state = IDLE;
      endcase

      // While scanning, loads are deferred to the frame boundary; a load
      // landing on the boundary cycle itself is the newest and goes direct.
      if (r_state != IDLE) begin
        if (w_frame_end) begin
          w_pending = 1'b0;
          if (load)           w_shadow = digits_in;
          else if (r_pending) w_shadow = r_staging;
        end else if (load) begin
          w_staging = digits_in;
          w_pending = 1'b1;
        end
      end
    end
  end

  // Unpack the next shadow word so outputs track the shadow update edge.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) w_dig[i] = w_shadow[4*i +: 4];
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_blank;
  always_comb begin
    logic acc;
    acc     = 1'b1;
    w_blank = '0;
    // Scan from the top digit down; digit 0 is never blanked.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      acc        = acc & (w_dig[i] == 4'h0);
      w_blank[i] = acc;
    end
  end
`endif

  // Output decode from next state so the registered outputs line up with it.
  always_comb begin
    w_an  = '1;
    w_bcd = 4'hF;
    if (w_state == SHOW) w_an[w_idx] = 1'b0;
    if (w_state != IDLE) begin
`ifdef LEADING_ZERO_BLANK_EN
      w_bcd = w_blank[w_idx] ? 4'hF : w_dig[w_idx];
`else
      w_bcd = w_dig[w_idx];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_staging <= '0;
      r_pending <= 1'b0;
      r_an      <= '1;
      r_bcd     <= 4'hF;
      r_fd      <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_cnt     <= w_cnt;
      r_shadow  <= w_shadow;
      r_staging <= w_staging;
      r_pending <= w_pending;
      r_an      <= w_an;
      r_bcd     <= w_bcd;
      r_fd      <= w_fd;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ = 4'hF;
`else
  localparam logic [3:0] LZ = 4'h0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, en, load;
  logic [15:0]   digits_in;
  logic [3:0]    bcd_out;
  logic [ND-1:0] an_n;
  logic          frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .bcd_out(bcd_out), .an_n(an_n), .frame_done(frame_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {logic [3:0] an; logic [3:0] bcd;} exp_t;
  exp_t q[$];
  exp_t e;

  task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    exp_t x;
    x.an  = a;
    x.bcd = b;
    q.push_back(x);
  endtask

  task automatic push_frame(input logic [3:0] b0, input logic [3:0] b1,
                            input logic [3:0] b2, input logic [3:0] b3);
    push(4'b1110, b0);
    push(4'b1101, b1);
    push(4'b1011, b2);
    push(4'b0111, b3);
  endtask

  task automatic wait_an(input logic [3:0] v, input string nm);
    int k = 0;
    while (an_n !== v && k < 100) begin tick(); k++; end
    check4(nm, an_n, v);
  endtask

  task automatic wait_fd(input string nm);
    int k = 0;
    while (frame_done !== 1'b1 && k < 60) begin tick(); k++; end
    checki(nm, int'(frame_done), 1);
  endtask

  // Monitor: each time a digit is lit (anode changes to a new low bit), pop
  // the next expected digit; also check the preceding blank cycle pre-settled
  // the decoder to the same code.
  logic [3:0] prev_an  = 4'hF;
  logic [3:0] prev_bcd = 4'hF;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && an_n !== 4'hF && an_n !== prev_an) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_digit: got an_n=%b bcd=%h, none expected", an_n, bcd_out);
      end else begin
        e = q.pop_front();
        check4("digit_an", an_n, e.an);
        check4("digit_bcd", bcd_out, e.bcd);
        check4("presettle_bcd", prev_bcd, e.bcd);
      end
    end
    prev_an  = an_n;
    prev_bcd = bcd_out;
  end

  initial begin
    int cnt;
    rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = '0;
    tick(); tick();
    check4("rst_an", an_n, 4'hF);
    check4("rst_bcd", bcd_out, 4'hF);
    checki("rst_fd", int'(frame_done), 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check4("idle_an", an_n, 4'hF);
    check4("idle_bcd", bcd_out, 4'hF);

    // Basic scan of 1234 with frame period measurement
    load = 1'b1; digits_in = 16'h1234; tick(); load = 1'b0;
    check4("idle_load_an", an_n, 4'hF);
    push_frame(4'h4, 4'h3, 4'h2, 4'h1);
    push_frame(4'h4, 4'h3, 4'h2, 4'h1);
    push_frame(4'h4, 4'h3, 4'h2, 4'h1);
    en = 1'b1; tick();
    check4("start_blank_an", an_n, 4'hF);
    check4("start_blank_bcd", bcd_out, 4'h4);
    wait_fd("fd_first");
    tick();
    checki("fd_one_cycle", int'(frame_done), 0);
    cnt = 1;
    while (frame_done !== 1'b1 && cnt < 40) begin tick(); cnt++; end
    checki("frame_period", cnt, 20);

    // Mid-frame load is deferred to the next frame
    wait_an(4'b1101, "t3_wait_d1");
    load = 1'b1; digits_in = 16'h5678; tick(); load = 1'b0;
    push_frame(4'h8, 4'h7, 4'h6, 4'h5);

    // Load on the frame-end cycle goes straight to the shadow
    wait_fd("t3_fd");
    wait_an(4'b0111, "t6_wait_d3");
    tick(); tick(); tick();
    push(4'b1110, 4'hB);
    push(4'b1101, 4'h0);
    push(4'b1011, 4'hA);
    load = 1'b1; digits_in = 16'h9A0B; tick(); load = 1'b0;
    checki("fe_fd", int'(frame_done), 1);
    check4("fe_bcd", bcd_out, 4'hB);

    // Drop en mid-SHOW of digit 2, then restart at digit 0
    wait_an(4'b1011, "t4_wait_d2");
    en = 1'b0; tick();
    check4("drop_an", an_n, 4'hF);
    check4("drop_bcd", bcd_out, 4'hF);
    checki("drop_fd", int'(frame_done), 0);
    tick(); tick();
    check4("dark_an", an_n, 4'hF);
    push_frame(4'hB, 4'h0, 4'hA, 4'h9);
    en = 1'b1; tick();
    check4("restart_blank_an", an_n, 4'hF);
    check4("restart_blank_bcd", bcd_out, 4'hB);
    wait_fd("t4_fd");
    en = 1'b0; tick();

    // Leading zeros
    load = 1'b1; digits_in = 16'h0045; tick(); load = 1'b0;
    push_frame(4'h5, 4'h4, LZ, LZ);
    en = 1'b1;
    wait_fd("t5_fd");
    en = 1'b0; tick();
    load = 1'b1; digits_in = 16'h0000; tick(); load = 1'b0;
    push(4'b1110, 4'h0);
    push(4'b1101, LZ);
    en = 1'b1;

    // Staged word is flushed to the shadow when en drops
    wait_an(4'b1101, "pend_wait_d1");
    load = 1'b1; digits_in = 16'h0987; tick(); load = 1'b0;
    en = 1'b0; tick();
    check4("pend_drop_an", an_n, 4'hF);
    push_frame(4'h7, 4'h8, 4'h9, LZ);
    push(4'b1110, 4'h7);
    en = 1'b1;
    wait_fd("pend_fd");
    wait_an(4'b1110, "rst_wait_d0");

    // Asynchronous reset mid-SHOW discards a pending load and clears shadow
    load = 1'b1; digits_in = 16'h1111; tick(); load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check4("async_rst_an", an_n, 4'hF);
    check4("async_rst_bcd", bcd_out, 4'hF);
    checki("async_rst_fd", int'(frame_done), 0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check4("post_rst_an", an_n, 4'hF);
    check4("post_rst_bcd", bcd_out, 4'hF);
    push_frame(4'h0, LZ, LZ, LZ);
    en = 1'b1;
    wait_fd("post_rst_fd");
    en = 1'b0;
    tick(); tick();

    checki("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
